// File: rtl/uart_tx_if.sv
// ----------------------------------------------------------------------------
// Module  : uart_tx_if
// Brief   : Parallel-in / serial-out handshake bundle for the UART transmitter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA_IN;
  logic                  DATA_VALID;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA_IN,
    output DATA_VALID,
    input  TX_OUT,
    input  BUSY
  );

  modport slave (
    input  P_DATA_IN,
    input  DATA_VALID,
    output TX_OUT,
    output BUSY
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// Module  : uart_tx
// Brief   : UART transmitter: start bit, LSB-first data, optional parity, stop.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 16,
  parameter int PAR_EN     = 0,
  parameter int PAR_TYPE   = 0
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PW-1:0] C_LAST_TICK = PW'(N - 1);
  localparam logic [BW-1:0] C_LAST_BIT  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            r_state,    w_state_nxt;
  logic [PW-1:0]         r_prescale, w_prescale_nxt;
  logic [BW-1:0]         r_bit_cnt,  w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shreg,    w_shreg_nxt;
  logic                  r_parity,   w_parity_nxt;
  logic                  r_tx,       w_tx_nxt;
  logic                  r_busy,     w_busy_nxt;
  logic                  w_bit_end;
  logic                  w_last_bit;

  assign w_bit_end  = (r_prescale == C_LAST_TICK);
  assign w_last_bit = (r_bit_cnt == C_LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prescale <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prescale <= w_prescale_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_parity   <= w_parity_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_prescale_nxt = w_bit_end ? '0 : r_prescale + PW'(1);
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shreg_nxt    = r_shreg;
    w_parity_nxt   = r_parity;
    case (r_state)
      S_IDLE: begin
        w_prescale_nxt = '0;
        w_bit_cnt_nxt  = '0;
        if (bus.DATA_VALID) begin
          w_state_nxt  = S_START;
          w_shreg_nxt  = bus.P_DATA_IN;
          w_parity_nxt = (PAR_TYPE != 0) ? ~^bus.P_DATA_IN : ^bus.P_DATA_IN;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shreg_nxt = r_shreg >> 1;
          if (w_last_bit) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PAR_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_prescale_nxt = '0;
        w_bit_cnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered line changes
  // on the same edge as the state itself.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shreg_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign bus.TX_OUT = r_tx;
  assign bus.BUSY   = r_busy;

endmodule

`default_nettype wire
